// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared defaults, entry layout and tag fold for the micro-BTB
// Purpose: parameter defaults, the table entry struct and the PC tag-fold
// function used by every micro-BTB file.
// Ports: none (package).
package bpu_pkg;

    localparam int BPU_MXLEN   = 32;
    localparam int BPU_SETS    = 16;
    localparam int BPU_WAYS    = 2;
    localparam int BPU_FETCH_W = 2;
    localparam int BPU_TAG_W   = 8;
    localparam int BPU_CTR_W   = 2;
    localparam int BPU_SLOT_W  = (BPU_FETCH_W > 1) ? $clog2(BPU_FETCH_W) : 1;

    typedef struct packed {
        logic                  valid;
        logic [BPU_TAG_W-1:0]  tag;
        logic [BPU_SLOT_W-1:0] slot;
        logic [BPU_MXLEN-1:0]  target;
        logic [BPU_CTR_W-1:0]  ctr;
    } ubtb_entry_t;

    // XOR together consecutive TAG_W-bit chunks of pc[MXLEN-1:lsb]; the
    // right shift zero-fills, which pads the topmost partial chunk.
    function automatic logic [BPU_TAG_W-1:0] fold_tag(input logic [BPU_MXLEN-1:0] pc,
                                                      input int lsb);
        logic [BPU_MXLEN-1:0] rest;
        logic [BPU_TAG_W-1:0] t;
        rest = pc >> lsb;
        t    = '0;
        for (int c = 0; c < (BPU_MXLEN + BPU_TAG_W - 1) / BPU_TAG_W; c++) begin
            t    = t ^ rest[BPU_TAG_W-1:0];
            rest = rest >> BPU_TAG_W;
        end
        return t;
    endfunction

endpackage

// File: rtl/ubtb_nway_if.sv
// rtl/ubtb_nway_if.sv - lookup/update/response bundle for the micro-BTB
// Purpose: groups the request, update, flush and response signals.
// Ports (seen from the predictor): i_req_vld/i_req_pc lookup request,
// i_upd_vld/i_upd_pc/i_upd_target/i_upd_taken resolved branch update,
// i_flush invalidate all, o_resp_vld/o_hit/o_slot/o_taken/o_target response.
// master = fetch/commit side, slave = predictor.
interface ubtb_nway_if
    import bpu_pkg::*;
#(
    parameter int MXLEN   = BPU_MXLEN,
    parameter int FETCH_W = BPU_FETCH_W
);
    localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

    logic              i_req_vld;
    logic [MXLEN-1:0]  i_req_pc;
    logic              i_upd_vld;
    logic [MXLEN-1:0]  i_upd_pc;
    logic [MXLEN-1:0]  i_upd_target;
    logic              i_upd_taken;
    logic              i_flush;
    logic              o_resp_vld;
    logic              o_hit;
    logic [SLOT_W-1:0] o_slot;
    logic              o_taken;
    logic [MXLEN-1:0]  o_target;

    modport master (
        output i_req_vld, i_req_pc, i_upd_vld, i_upd_pc, i_upd_target, i_upd_taken, i_flush,
        input  o_resp_vld, o_hit, o_slot, o_taken, o_target
    );

    modport slave (
        input  i_req_vld, i_req_pc, i_upd_vld, i_upd_pc, i_upd_target, i_upd_taken, i_flush,
        output o_resp_vld, o_hit, o_slot, o_taken, o_target
    );

endinterface

// File: rtl/ubtb_hash.sv
// rtl/ubtb_hash.sv - splits a PC into set index, fetch slot and folded tag
// Purpose: address decomposition shared by the lookup and update paths.
// Ports: pc in; index, slot, tag out (purely combinational).
module ubtb_hash
    import bpu_pkg::*;
#(
    parameter int MXLEN   = BPU_MXLEN,
    parameter int SETS    = BPU_SETS,
    parameter int FETCH_W = BPU_FETCH_W,
    parameter int TAG_W   = BPU_TAG_W,
    localparam int IDX_W  = $clog2(SETS),
    localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
    input  logic [MXLEN-1:0]  pc,
    output logic [IDX_W-1:0]  index,
    output logic [SLOT_W-1:0] slot,
    output logic [TAG_W-1:0]  tag
);
    localparam int OFF = 2 + $clog2(FETCH_W);

    // Instruction-alignment bits never take part in prediction.
    logic unused_low;
    assign unused_low = ^pc[1:0];

    generate
        if (FETCH_W > 1) begin : g_slot
            assign slot = pc[OFF-1:2];
        end else begin : g_noslot
            assign slot = '0;
        end
    endgenerate

    assign index = pc[OFF+IDX_W-1:OFF];
    assign tag   = fold_tag(pc, OFF + IDX_W);

endmodule

// File: rtl/ubtb_nway.sv
// rtl/ubtb_nway.sv - set-associative micro branch target buffer
// Purpose: flop-based N-way BTB with per-entry saturating direction counter,
// registered lookup response, single-cycle flush and round-robin victims.
// Ports: i_clk clock; i_rstn async active-low reset; bus (slave) carries
// lookup request, resolved-branch update, flush and the lookup response.
module ubtb_nway
    import bpu_pkg::*;
#(
    parameter int MXLEN   = BPU_MXLEN,
    parameter int SETS    = BPU_SETS,
    parameter int WAYS    = BPU_WAYS,
    parameter int FETCH_W = BPU_FETCH_W,
    parameter int TAG_W   = BPU_TAG_W,
    parameter int CTR_W   = BPU_CTR_W
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    ubtb_nway_if.slave  bus
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

    ubtb_entry_t      table_q [SETS][WAYS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [IDX_W-1:0]  lk_idx,  up_idx;
    logic [SLOT_W-1:0] lk_slot, up_slot;
    logic [TAG_W-1:0]  lk_tag,  up_tag;

    ubtb_hash #(.MXLEN(MXLEN), .SETS(SETS), .FETCH_W(FETCH_W), .TAG_W(TAG_W)) u_hash_lk (
        .pc    (bus.i_req_pc),
        .index (lk_idx),
        .slot  (lk_slot),
        .tag   (lk_tag)
    );

    ubtb_hash #(.MXLEN(MXLEN), .SETS(SETS), .FETCH_W(FETCH_W), .TAG_W(TAG_W)) u_hash_up (
        .pc    (bus.i_upd_pc),
        .index (up_idx),
        .slot  (up_slot),
        .tag   (up_tag)
    );

    // Lookup: among matching ways keep the lowest entry slot; strict '<'
    // means an equal slot in a higher way never displaces a lower way.
    logic              lk_hit;
    logic [SLOT_W-1:0] lk_best_slot;
    logic [MXLEN-1:0]  lk_best_target;
    logic              lk_best_taken;

    always_comb begin
        lk_hit         = 1'b0;
        lk_best_slot   = '0;
        lk_best_target = '0;
        lk_best_taken  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (table_q[lk_idx][w].valid &&
                table_q[lk_idx][w].tag == lk_tag &&
                table_q[lk_idx][w].slot >= lk_slot) begin
                if (!lk_hit || table_q[lk_idx][w].slot < lk_best_slot) begin
                    lk_hit         = 1'b1;
                    lk_best_slot   = table_q[lk_idx][w].slot;
                    lk_best_target = table_q[lk_idx][w].target;
                    lk_best_taken  = table_q[lk_idx][w].ctr[CTR_W-1];
                end
            end
        end
    end

    // Update: exact-slot match trains the existing entry; a taken miss
    // allocates into the first free way, else the round-robin way.
    logic             um_hit;
    logic [WAY_W-1:0] um_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] vic_way;
    logic [WAY_W-1:0] rr_next;
    logic             wr_en;
    logic [WAY_W-1:0] wr_way;
    ubtb_entry_t      wr_entry;
    logic             rr_adv;

    always_comb begin
        um_hit    = 1'b0;
        um_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!um_hit && table_q[up_idx][w].valid &&
                table_q[up_idx][w].tag == up_tag &&
                table_q[up_idx][w].slot == up_slot) begin
                um_hit = 1'b1;
                um_way = WAY_W'(w);
            end
            if (!inv_found && !table_q[up_idx][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vic_way = inv_found ? inv_way : rr_q[up_idx];
        rr_next = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + WAY_W'(1);
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_way   = vic_way;
        wr_entry = '0;
        rr_adv   = 1'b0;
        if (bus.i_upd_vld && !bus.i_flush) begin
            if (um_hit) begin
                wr_en    = 1'b1;
                wr_way   = um_way;
                wr_entry = table_q[up_idx][um_way];
                if (bus.i_upd_taken) begin
                    wr_entry.target = bus.i_upd_target;
                    if (wr_entry.ctr != '1) begin
                        wr_entry.ctr = wr_entry.ctr + CTR_W'(1);
                    end
                end else if (wr_entry.ctr != '0) begin
                    wr_entry.ctr = wr_entry.ctr - CTR_W'(1);
                end
            end else if (bus.i_upd_taken) begin
                wr_en           = 1'b1;
                wr_way          = vic_way;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = up_tag;
                wr_entry.slot   = up_slot;
                wr_entry.target = bus.i_upd_target;
                wr_entry.ctr    = CTR_WEAK;
                rr_adv          = !inv_found;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    table_q[s][w] <= '0;
                end
            end
        end else if (bus.i_flush) begin
            // Round-robin pointers deliberately survive a flush.
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    table_q[s][w].valid <= 1'b0;
                end
            end
        end else begin
            if (wr_en) begin
                table_q[up_idx][wr_way] <= wr_entry;
            end
            if (rr_adv) begin
                rr_q[up_idx] <= rr_next;
            end
        end
    end

    // Response registers sample pre-update table state; every field is
    // forced to zero unless a real hit is being reported.
    logic              resp_vld_q;
    logic              hit_q;
    logic [SLOT_W-1:0] slot_q;
    logic              taken_q;
    logic [MXLEN-1:0]  target_q;
    logic              rsp_live;
    logic              rsp_hit;

    assign rsp_live = bus.i_req_vld && !bus.i_flush;
    assign rsp_hit  = rsp_live && lk_hit;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            resp_vld_q <= 1'b0;
            hit_q      <= 1'b0;
            slot_q     <= '0;
            taken_q    <= 1'b0;
            target_q   <= '0;
        end else begin
            resp_vld_q <= rsp_live;
            hit_q      <= rsp_hit;
            slot_q     <= rsp_hit ? lk_best_slot   : '0;
            taken_q    <= rsp_hit ? lk_best_taken  : 1'b0;
            target_q   <= rsp_hit ? lk_best_target : '0;
        end
    end

    assign bus.o_resp_vld = resp_vld_q;
    assign bus.o_hit      = hit_q;
    assign bus.o_slot     = slot_q;
    assign bus.o_taken    = taken_q;
    assign bus.o_target   = target_q;

endmodule

// File: tb/tb_ubtb_nway.sv
// tb/tb_ubtb_nway.sv - randomized and directed self-checking bench for ubtb_nway
module tb_ubtb_nway;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ubtb_nway_if #(.MXLEN(32), .FETCH_W(2)) bus ();

    ubtb_nway #(
        .MXLEN(32), .SETS(16), .WAYS(2), .FETCH_W(2), .TAG_W(8), .CTR_W(2)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference table: plain arrays indexed [set][way].
    bit          m_valid [16][2];
    logic [7:0]  m_tag   [16][2];
    int          m_slot  [16][2];
    logic [31:0] m_tgt   [16][2];
    int          m_ctr   [16][2];
    int          m_rr    [16];

    logic        e_vld, e_hit, e_taken;
    logic [0:0]  e_slot;
    logic [31:0] e_tgt;

    function automatic logic [7:0] f_tag(input logic [31:0] pc);
        logic [31:0] x;
        logic [7:0]  t;
        x = pc >> 7;
        t = 8'h00;
        for (int k = 0; k < 4; k++) begin
            t = t ^ x[7:0];
            x = x >> 8;
        end
        return t;
    endfunction

    function automatic int f_idx(input logic [31:0] pc);
        return int'((pc >> 3) & 32'hF);
    endfunction

    function automatic int f_slot(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h1);
    endfunction

    task automatic model_clear(input bit with_rr);
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                if (with_rr) begin
                    m_ctr[s][w] = 0;
                end
            end
            if (with_rr) m_rr[s] = 0;
        end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        int s, sl, hw, vw;
        logic [7:0] t;
        s  = f_idx(pc);
        sl = f_slot(pc);
        t  = f_tag(pc);
        hw = -1;
        for (int w = 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == t && m_slot[s][w] == sl) hw = w;
        if (hw >= 0) begin
            if (tk) begin
                m_ctr[s][hw] = (m_ctr[s][hw] < 3) ? m_ctr[s][hw] + 1 : 3;
                m_tgt[s][hw] = tgt;
            end else begin
                m_ctr[s][hw] = (m_ctr[s][hw] > 0) ? m_ctr[s][hw] - 1 : 0;
            end
        end else if (tk) begin
            vw = -1;
            for (int w = 1; w >= 0; w--)
                if (!m_valid[s][w]) vw = w;
            if (vw < 0) begin
                vw = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % 2;
            end
            m_valid[s][vw] = 1'b1;
            m_tag[s][vw]   = t;
            m_slot[s][vw]  = sl;
            m_tgt[s][vw]   = tgt;
            m_ctr[s][vw]   = 2;
        end
    endtask

    // Drives one cycle, predicts the response from the pre-update model,
    // then advances the model; outputs are stable on return.
    task automatic do_cycle(input logic rv, input logic [31:0] rpc,
                            input logic uv, input logic [31:0] upc,
                            input logic [31:0] ut, input logic tk, input logic fl);
        int s, rs, best;
        logic [7:0] t;
        e_vld = 0; e_hit = 0; e_slot = 0; e_taken = 0; e_tgt = 0;
        if (rv && !fl) begin
            e_vld = 1;
            s  = f_idx(rpc);
            rs = f_slot(rpc);
            t  = f_tag(rpc);
            best = 99;
            for (int w = 0; w < 2; w++) begin
                if (m_valid[s][w] && m_tag[s][w] == t && m_slot[s][w] >= rs && m_slot[s][w] < best) begin
                    best    = m_slot[s][w];
                    e_hit   = 1;
                    e_slot  = 1'(m_slot[s][w]);
                    e_tgt   = m_tgt[s][w];
                    e_taken = (m_ctr[s][w] >= 2);
                end
            end
        end
        if (fl) model_clear(1'b0);
        else if (uv) model_update(upc, ut, tk);
        bus.i_req_vld    = rv;
        bus.i_req_pc     = rpc;
        bus.i_upd_vld    = uv;
        bus.i_upd_pc     = upc;
        bus.i_upd_target = ut;
        bus.i_upd_taken  = tk;
        bus.i_flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_clear(1'b1);
        bus.i_req_vld = 1; bus.i_req_pc = 32'h1000;
        bus.i_upd_vld = 1; bus.i_upd_pc = 32'h1000; bus.i_upd_target = 32'h4;
        bus.i_upd_taken = 1; bus.i_flush = 0;
        rstn = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%h want all zero",
                     bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target);
        end
        bus.i_req_vld = 0; bus.i_upd_vld = 0;
        #2 rstn = 1;
        do_cycle(0, 0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.o_resp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_resp: got %b want 0", bus.o_resp_vld);
        end
        do_cycle(1, 32'h1000, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_update_dropped: got vld=%b hit=%b want vld=1 hit=0", bus.o_resp_vld, bus.o_hit);
        end
    endtask

    task automatic test_basic();
        do_cycle(0, 0, 1, 32'h1004, 32'h2000, 1, 0);
        do_cycle(1, 32'h1000, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== {4'b1111, 32'h2000}) begin
            n_bad++;
            $display("FAIL basic_hit: got %b/%b/%b/%b/%h want 1/1/1/1/00002000",
                     bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target);
        end
        do_cycle(1, 32'h1008, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== {4'b1000, 32'h0}) begin
            n_bad++;
            $display("FAIL basic_miss: got %b/%b/%b/%b/%h want 1/0/0/0/0",
                     bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target);
        end
    endtask

    task automatic test_evict();
        logic [31:0] pcs [3];
        logic [1:0]  want;
        pcs[0] = 32'h1000; pcs[1] = 32'h1080; pcs[2] = 32'h1100;
        do_cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, pcs[i], 32'h5000 + 32'(i * 16), 1, 0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, pcs[i], 0, 0, 0, 0, 0);
            want = (i == 0) ? 2'b10 : 2'b11;
            n_cmp++;
            if ({bus.o_resp_vld, bus.o_hit} !== want) begin
                n_bad++;
                $display("FAIL evict_lookup_%0d: got vld=%b hit=%b want %b", i, bus.o_resp_vld, bus.o_hit, want);
            end
            n_cmp++;
            if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== {e_vld, e_hit, e_slot, e_taken, e_tgt}) begin
                n_bad++;
                $display("FAIL evict_model_%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", i,
                         bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target,
                         e_vld, e_hit, e_slot, e_taken, e_tgt);
            end
        end
    endtask

    task automatic test_ctr();
        logic [3:0] want_tk;
        do_cycle(0, 0, 0, 0, 0, 0, 1);
        do_cycle(0, 0, 1, 32'h1004, 32'h2000, 1, 0);
        // not-taken x3 then taken x2: ctr 10->01->00->00->01->10
        want_tk = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            do_cycle(0, 0, 1, 32'h1004, 32'h2000, (i >= 3), 0);
            if (i >= 1) begin
                do_cycle(1, 32'h1004, 0, 0, 0, 0, 0);
                n_cmp++;
                if ({bus.o_hit, bus.o_taken} !== {1'b1, want_tk[i-1]}) begin
                    n_bad++;
                    $display("FAIL ctr_step_%0d: got hit=%b taken=%b want hit=1 taken=%b",
                             i, bus.o_hit, bus.o_taken, want_tk[i-1]);
                end
            end
        end
    endtask

    task automatic test_flush();
        do_cycle(1, 32'h1004, 1, 32'h1200, 32'h7000, 1, 1);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit} !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_resp: got vld=%b hit=%b want 0/0", bus.o_resp_vld, bus.o_hit);
        end
        do_cycle(1, 32'h1200, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit} !== 2'b10) begin
            n_bad++;
            $display("FAIL flush_upd_dropped: got vld=%b hit=%b want 1/0", bus.o_resp_vld, bus.o_hit);
        end
        do_cycle(1, 32'h1004, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit} !== 2'b10) begin
            n_bad++;
            $display("FAIL flush_cleared: got vld=%b hit=%b want 1/0", bus.o_resp_vld, bus.o_hit);
        end
    endtask

    task automatic test_same_cycle();
        do_cycle(0, 0, 1, 32'h2044, 32'hA000, 1, 0);
        do_cycle(1, 32'h2044, 1, 32'h2044, 32'hB000, 1, 0);
        n_cmp++;
        if ({bus.o_hit, bus.o_target} !== {1'b1, 32'hA000}) begin
            n_bad++;
            $display("FAIL same_cycle_old: got hit=%b tgt=%h want 1/0000a000", bus.o_hit, bus.o_target);
        end
        do_cycle(1, 32'h2044, 0, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.o_hit, bus.o_target} !== {1'b1, 32'hB000}) begin
            n_bad++;
            $display("FAIL same_cycle_new: got hit=%b tgt=%h want 1/0000b000", bus.o_hit, bus.o_target);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = 32'h0000_1000;
        pc = pc | (32'($urandom_range(0, 2)) << 7);
        pc = pc | (32'($urandom_range(0, 3)) << 3);
        pc = pc | (32'($urandom_range(0, 1)) << 2);
        pc = pc | (32'($urandom_range(0, 1)) << 20);
        pc = pc | (32'($urandom_range(0, 1)) << 31);
        pc = pc | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 600; i++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), rand_pc(),
                     1'($urandom_range(0, 1)), rand_pc(), $urandom(),
                     1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
            n_cmp++;
            if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== {e_vld, e_hit, e_slot, e_taken, e_tgt}) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got %b/%b/%b/%b/%h want %b/%b/%b/%b/%h", i,
                             bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target,
                             e_vld, e_hit, e_slot, e_taken, e_tgt);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] pcs [3];
        pcs[0] = 32'h1000; pcs[1] = 32'h2044; pcs[2] = 32'h300C;
        do_cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 1, pcs[i], 32'hC000 + 32'(i), 1, 0);
        do_cycle(1, pcs[1], 0, 0, 0, 0, 0);
        n_cmp++;
        if (bus.o_hit !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_prehit: got hit=%b want 1", bus.o_hit);
        end
        #2 rstn = 0;
        #1;
        n_cmp++;
        if ({bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target} !== 36'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b/%b/%b/%b/%h want all zero",
                     bus.o_resp_vld, bus.o_hit, bus.o_slot, bus.o_taken, bus.o_target);
        end
        model_clear(1'b1);
        bus.i_req_vld = 1; bus.i_req_pc = pcs[0];
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_resp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_held: got vld=%b want 0", bus.o_resp_vld);
        end
        bus.i_req_vld = 0;
        #2 rstn = 1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.o_resp_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_noresp: got vld=%b want 0", bus.o_resp_vld);
        end
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, pcs[i], 0, 0, 0, 0, 0);
            n_cmp++;
            if ({bus.o_resp_vld, bus.o_hit} !== 2'b10) begin
                n_bad++;
                $display("FAIL rstmid_miss_%0d: got vld=%b hit=%b want 1/0", i, bus.o_resp_vld, bus.o_hit);
            end
        end
    endtask

    initial begin
        bus.i_req_vld = 0; bus.i_req_pc = 0; bus.i_upd_vld = 0; bus.i_upd_pc = 0;
        bus.i_upd_target = 0; bus.i_upd_taken = 0; bus.i_flush = 0;
        test_reset();
        test_basic();
        test_evict();
        test_ctr();
        test_flush();
        test_same_cycle();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
